mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns, sign/zero-extends and read-modify-writes
// sub-word stores against a word-wide data memory with a ready handshake and timeout.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        stall_o,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        misalign_o,
   output logic        err_o,
   output logic        MemRead_o,
   output logic        MemWrite_o,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   input  logic [31:0] data_i,
   input  logic        mem_ready_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RMW_RD,
      S_RMW_WR,
      S_WR,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [1:0]         off_q, off_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        data_q, data_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               resp_valid_q, resp_valid_d;
   logic               err_q, err_d;
   logic               mem_read_q, mem_read_d;
   logic               mem_write_q, mem_write_d;

   logic               misaligned_c;
   logic               accept_c;
   logic               strobe_c;
   logic               timeout_c;
   logic [4:0]         sh_c;
   logic [31:0]        lane_c;
   logic [31:0]        load_ext_c;
   logic [31:0]        lane_mask_c;
   logic [31:0]        merged_c;

   // Request qualification against the live inputs (only meaningful in IDLE)
   always_comb begin
      misaligned_c = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                     (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
      accept_c     = (state_q == S_IDLE) && req_valid_i && !misaligned_c;
   end

   // Lane extraction and merge datapath on the latched request
   always_comb begin
      sh_c        = {off_q, 3'b000};
      lane_c      = data_i >> sh_c;
      unique case (size_q)
         2'b00:   load_ext_c = uns_q ? {24'b0, lane_c[7:0]}  : {{24{lane_c[7]}}, lane_c[7:0]};
         2'b01:   load_ext_c = uns_q ? {16'b0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
         default: load_ext_c = lane_c;
      endcase
      lane_mask_c = (size_q == 2'b00) ? (32'h0000_00FF << sh_c) : (32'h0000_FFFF << sh_c);
      merged_c    = (data_i & ~lane_mask_c) | ((wdata_q << sh_c) & lane_mask_c);
      strobe_c    = mem_read_q || mem_write_q;
      timeout_c   = strobe_c && !mem_ready_i && (cnt_q == CNT_LAST);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      addr_d       = addr_q;
      data_d       = data_q;
      rdata_d      = rdata_q;
      err_d        = 1'b0;
      resp_valid_d = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      cnt_d        = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               off_d   = req_addr_i[1:0];
               wdata_d = req_wdata_i;
               addr_d  = {req_addr_i[31:2], 2'b00};
               if (!req_write_i) begin
                  state_d = S_RD;
               end else if (req_size_i[1]) begin
                  data_d  = req_wdata_i;
                  state_d = S_WR;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_RD: begin
            if (mem_ready_i) begin
               rdata_d = load_ext_c;
               state_d = S_DONE;
            end else if (timeout_c) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_RMW_RD: begin
            if (mem_ready_i) begin
               data_d  = merged_c;
               state_d = S_RMW_WR;
            end else if (timeout_c) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_RMW_WR, S_WR: begin
            if (mem_ready_i || timeout_c) begin
               rdata_d = 32'h0;
               err_d   = !mem_ready_i;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_read_d   = (state_d == S_RD) || (state_d == S_RMW_RD);
      mem_write_d  = (state_d == S_WR) || (state_d == S_RMW_WR);
      resp_valid_d = (state_d == S_DONE);

      // Wait counter restarts on every state entry
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (strobe_c && !mem_ready_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         off_q        <= 2'b00;
         wdata_q      <= 32'h0;
         addr_q       <= 32'h0;
         data_q       <= 32'h0;
         rdata_q      <= 32'h0;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
         err_q        <= err_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   // Stall and misalign follow the live request, forced low while in reset
   always_comb begin
      stall_o    = rst_n_i && (accept_c || (state_q == S_RD) || (state_q == S_RMW_RD) ||
                               (state_q == S_RMW_WR) || (state_q == S_WR));
      misalign_o = rst_n_i && (state_q == S_IDLE) && req_valid_i && misaligned_c;
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = rdata_q;
   assign err_o        = err_q;
   assign MemRead_o    = mem_read_q;
   assign MemWrite_o   = mem_write_q;
   assign addr_o       = addr_q;
   assign data_o       = data_q;

endmodule
